// File: rtl/dll_pkg.sv
// dll_pkg: shared definitions for the DLL lock controller.
//   dll_state_t : controller state encoding (IDLE=0, COARSE=1, FINE=2, LOCKED=3)
//   DIR_UP/DIR_DN : phase-comparator direction values
package dll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } dll_state_t;

  localparam logic DIR_UP = 1'b1;  // delay too short, increase
  localparam logic DIR_DN = 1'b0;  // delay too long, decrease

endpackage

// File: rtl/dll_settle_timer.sv
// dll_settle_timer: reloadable down-counter that paces comparator sampling.
//   Parameter SETTLE_CYC (>=2): cycles between ticks.
//   Ports:
//     clk     in  clock
//     rst     in  synchronous active-high reset (count cleared)
//     i_load  in  load SETTLE_CYC-1 (entry into the search)
//     i_run   in  count down while high
//     o_tick  out one-cycle pulse when the count is 0 while running;
//                 the counter reloads on the same edge
module dll_settle_timer #(
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_tick
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_run) begin
      if (r_cnt == '0) r_cnt <= RELOAD;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/dll_lock_ctrl.sv
// dll_lock_ctrl: DLL lock controller. Coarse binary-direction search, then
// fine thermometer tracking with carry/borrow into the coarse code, lock
// after LOCK_TOGGLES consecutive direction reversals.
//   Ports:
//     clk          in  clock
//     rst          in  synchronous active-high reset
//     en           in  run controller; low returns to IDLE
//     comp_in      in  phase comparator (1 = increase delay, 0 = decrease)
//     coarse_code  out coarse delay select (registered)
//     fine_code    out fine thermometer code, LSB-filled (registered)
//     locked       out lock indication (registered)
//     busy         out state is COARSE or FINE (combinational)
//     sat_err      out sticky coarse saturation flag (registered)
//   Build option: define DLL_LOCK_HYST_EN to unlock on UNLOCK_LIMIT
//   consecutive same-direction ticks instead of on any carry/borrow.
module dll_lock_ctrl
  import dll_pkg::*;
#(
  parameter int unsigned COARSE_W     = 5,
  parameter int unsigned FINE_W       = 16,
  parameter int unsigned SETTLE_CYC   = 8,
  parameter int unsigned LOCK_TOGGLES = 4,
  parameter int unsigned UNLOCK_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                comp_in,
  output logic [COARSE_W-1:0] coarse_code,
  output logic [FINE_W-1:0]   fine_code,
  output logic                locked,
  output logic                busy,
  output logic                sat_err
);

  localparam logic [COARSE_W-1:0] COARSE_MID = {1'b1, {(COARSE_W-1){1'b0}}};
  localparam logic [FINE_W-1:0]   FINE_HALF  =
    {{(FINE_W - FINE_W/2){1'b0}}, {(FINE_W/2){1'b1}}};
  localparam int unsigned TOG_W = $clog2(LOCK_TOGGLES + 1);

  dll_state_t          r_state, w_state_nx;
  logic [COARSE_W-1:0] r_coarse, w_coarse_nx;
  logic [FINE_W-1:0]   r_fine, w_fine_nx;
  logic                r_locked, w_locked_nx;
  logic                r_sat, w_sat_nx;
  logic                r_dir0, w_dir0_nx;
  logic                r_first, w_first_nx;
  logic                r_prev, w_prev_nx;
  logic [TOG_W-1:0]    r_tog, w_tog_nx, w_tog_inc;
  logic                w_wrap;
  logic                w_tick, w_load, w_run;

`ifdef DLL_LOCK_HYST_EN
  localparam int unsigned RUN_W = $clog2(UNLOCK_LIMIT + 1);
  logic [RUN_W-1:0] r_run, w_run_nx, w_run_inc;
`endif

  assign w_load = (r_state == ST_IDLE) && en;
  assign w_run  = (r_state != ST_IDLE) && en;

  dll_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_run  (w_run),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_coarse_nx = r_coarse;
    w_fine_nx   = r_fine;
    w_locked_nx = r_locked;
    w_sat_nx    = r_sat;
    w_dir0_nx   = r_dir0;
    w_first_nx  = r_first;
    w_prev_nx   = r_prev;
    w_tog_nx    = r_tog;
    w_tog_inc   = '0;
    w_wrap      = 1'b0;
`ifdef DLL_LOCK_HYST_EN
    w_run_nx    = r_run;
    w_run_inc   = '0;
`endif

    if (!en) begin
      w_state_nx  = ST_IDLE;
      w_locked_nx = 1'b0;
      w_sat_nx    = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_COARSE;
          w_first_nx = 1'b1;
        end

        ST_COARSE: begin
          if (w_tick) begin
            w_prev_nx = comp_in;
            if (r_first || (comp_in == r_dir0)) begin
              w_first_nx = 1'b0;
              if (r_first) w_dir0_nx = comp_in;
              if (comp_in == DIR_UP) begin
                if (r_coarse == '1) w_sat_nx = 1'b1;
                else                w_coarse_nx = r_coarse + 1'b1;
              end else begin
                if (r_coarse == '0) w_sat_nx = 1'b1;
                else                w_coarse_nx = r_coarse - 1'b1;
              end
            end else begin
              w_state_nx = ST_FINE;
              w_fine_nx  = FINE_HALF;
              w_tog_nx   = '0;
            end
          end
        end

        ST_FINE, ST_LOCKED: begin
          if (w_tick) begin
            w_prev_nx = comp_in;
            // Fine thermometer step; overflow either way spills into coarse.
            if (comp_in == DIR_UP) begin
              if (&r_fine) begin
                w_wrap = 1'b1;
                if (r_coarse == '1) begin
                  w_sat_nx = 1'b1;
                end else begin
                  w_fine_nx   = '0;
                  w_coarse_nx = r_coarse + 1'b1;
                end
              end else begin
                w_fine_nx = {r_fine[FINE_W-2:0], 1'b1};
              end
            end else begin
              if (r_fine == '0) begin
                w_wrap = 1'b1;
                if (r_coarse == '0) begin
                  w_sat_nx = 1'b1;
                end else begin
                  w_fine_nx   = '1;
                  w_coarse_nx = r_coarse - 1'b1;
                end
              end else begin
                w_fine_nx = {1'b0, r_fine[FINE_W-1:1]};
              end
            end

            if (r_state == ST_FINE) begin
              w_tog_inc = (comp_in != r_prev) ? r_tog + 1'b1 : '0;
              w_tog_nx  = w_tog_inc;
              if (w_tog_inc == TOG_W'(LOCK_TOGGLES)) begin
                w_state_nx  = ST_LOCKED;
                w_locked_nx = 1'b1;
`ifdef DLL_LOCK_HYST_EN
                w_run_nx    = '0;
`endif
              end
            end else begin
`ifdef DLL_LOCK_HYST_EN
              // A reversal starts a new run of length one.
              w_run_inc = (comp_in != r_prev) ? RUN_W'(1) : r_run + 1'b1;
              w_run_nx  = w_run_inc;
              if (w_run_inc == RUN_W'(UNLOCK_LIMIT)) begin
                w_state_nx  = ST_FINE;
                w_locked_nx = 1'b0;
                w_tog_nx    = '0;
              end
`else
              if (w_wrap) begin
                w_state_nx  = ST_FINE;
                w_locked_nx = 1'b0;
                w_tog_nx    = '0;
              end
`endif
            end
          end
        end

        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_coarse <= COARSE_MID;
      r_fine   <= '0;
      r_locked <= 1'b0;
      r_sat    <= 1'b0;
      r_dir0   <= 1'b0;
      r_first  <= 1'b0;
      r_prev   <= 1'b0;
      r_tog    <= '0;
`ifdef DLL_LOCK_HYST_EN
      r_run    <= '0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_coarse <= w_coarse_nx;
      r_fine   <= w_fine_nx;
      r_locked <= w_locked_nx;
      r_sat    <= w_sat_nx;
      r_dir0   <= w_dir0_nx;
      r_first  <= w_first_nx;
      r_prev   <= w_prev_nx;
      r_tog    <= w_tog_nx;
`ifdef DLL_LOCK_HYST_EN
      r_run    <= w_run_nx;
`endif
    end
  end

  assign coarse_code = r_coarse;
  assign fine_code   = r_fine;
  assign locked      = r_locked;
  assign sat_err     = r_sat;
  assign busy        = (r_state == ST_COARSE) || (r_state == ST_FINE);

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// tb_dll_lock_ctrl: scoreboard bench for dll_lock_ctrl with COARSE_W=5,
// FINE_W=8, SETTLE_CYC=4, LOCK_TOGGLES=4. Expected output tuples are queued
// as stimulus is applied and popped after the corresponding edge.
module tb_dll_lock_ctrl;

  localparam int unsigned SETTLE = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       comp_in;
  logic [4:0] coarse_code;
  logic [7:0] fine_code;
  logic       locked;
  logic       busy;
  logic       sat_err;

  int unsigned n_chk;
  int unsigned n_bad;

  typedef struct {
    string      tag;
    logic [4:0] coarse;
    logic [7:0] fine;
    logic       lk;
    logic       bsy;
    logic       sat;
  } exp_t;

  exp_t sb[$];

`ifdef DLL_LOCK_HYST_EN
  localparam logic LK4 = 1'b0;
`else
  localparam logic LK4 = 1'b1;
`endif

  dll_lock_ctrl #(
    .COARSE_W     (5),
    .FINE_W       (8),
    .SETTLE_CYC   (SETTLE),
    .LOCK_TOGGLES (4),
    .UNLOCK_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .comp_in     (comp_in),
    .coarse_code (coarse_code),
    .fine_code   (fine_code),
    .locked      (locked),
    .busy        (busy),
    .sat_err     (sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [4:0] c, input logic [7:0] f,
                      input logic lk, input logic bsy, input logic sat);
    exp_t e;
    e.tag = tag; e.coarse = c; e.fine = f; e.lk = lk; e.bsy = bsy; e.sat = sat;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".coarse"}, 32'(coarse_code), 32'(e.coarse));
      chk({e.tag, ".fine"},   32'(fine_code),   32'(e.fine));
      chk({e.tag, ".locked"}, 32'(locked),      32'(e.lk));
      chk({e.tag, ".busy"},   32'(busy),        32'(e.bsy));
      chk({e.tag, ".sat"},    32'(sat_err),     32'(e.sat));
    end
  endtask

  // Drive one comparator value for a full settle interval and check the
  // outputs right after the tick edge.
  task automatic tick(input logic c, input string tag, input logic [4:0] co,
                      input logic [7:0] f, input logic lk, input logic bsy,
                      input logic sat);
    comp_in = c;
    push(tag, co, f, lk, bsy, sat);
    step(SETTLE);
    pop_check();
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1; en = 1'b0; comp_in = 1'b0;
    step(2);
    push("reset", 5'd16, 8'h00, 1'b0, 1'b0, 1'b0);
    pop_check();
    rst = 1'b0;

    // Coarse search: three up-steps, then a reversal enters FINE.
    en = 1'b1;
    push("entry", 5'd16, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1);
    pop_check();
    comp_in = 1'b1;
    push("pre_tick", 5'd16, 8'h00, 1'b0, 1'b1, 1'b0);
    step(SETTLE - 1);
    pop_check();
    push("c1", 5'd17, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1);
    pop_check();
    tick(1'b1, "c2", 5'd18, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(1'b1, "c3", 5'd19, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(1'b0, "to_fine", 5'd19, 8'h0F, 1'b0, 1'b1, 1'b0);

    // Four reversals lock on the fourth tick.
    tick(1'b1, "l1", 5'd19, 8'h1F, 1'b0, 1'b1, 1'b0);
    tick(1'b0, "l2", 5'd19, 8'h0F, 1'b0, 1'b1, 1'b0);
    tick(1'b1, "l3", 5'd19, 8'h1F, 1'b0, 1'b1, 1'b0);
    tick(1'b0, "l4", 5'd19, 8'h0F, 1'b1, 1'b0, 1'b0);

    // Fill fine to all-ones, then carry into coarse.
    tick(1'b1, "r1", 5'd19, 8'h1F, 1'b1, 1'b0, 1'b0);
    tick(1'b1, "r2", 5'd19, 8'h3F, 1'b1, 1'b0, 1'b0);
    tick(1'b1, "r3", 5'd19, 8'h7F, 1'b1, 1'b0, 1'b0);
    tick(1'b1, "r4", 5'd19, 8'hFF, LK4, ~LK4, 1'b0);
    tick(1'b1, "carry", 5'd20, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(1'b0, "borrow", 5'd19, 8'hFF, 1'b0, 1'b1, 1'b0);

    // Abort mid-FINE: codes held in IDLE.
    en = 1'b0;
    push("abort", 5'd19, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1);
    pop_check();
    push("idle_hold", 5'd19, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(3);
    pop_check();

    // Re-enable from held codes and climb into the upper limit.
    en = 1'b1;
    comp_in = 1'b1;
    step(1);
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, "climb", 5'(20 + k), 8'hFF, 1'b0, 1'b1, 1'b0);
    end
    tick(1'b1, "sat", 5'd31, 8'hFF, 1'b0, 1'b1, 1'b1);
    en = 1'b0;
    push("sat_clr", 5'd31, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1);
    pop_check();

    // Reset in the middle of a coarse interval.
    en = 1'b1;
    step(3);
    rst = 1'b1;
    push("rst_mid", 5'd16, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1);
    pop_check();
    rst = 1'b0;
    en = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
